// File: rtl/direction_ctrl.sv
// Direction-key front end for Snake-and-Apples: debounces four key levels, makes press pulses,
// and keeps the pending/committed heading with a no-reversal rule, committing on each game tick.
module direction_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_right,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       tick,
    output logic [3:0] key_pulse,
    output logic [1:0] dir,
    output logic       turn
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Bit order matches key_pulse and the heading encoding: bit i is heading i.
    logic [3:0]       raw;
    logic [CNT_W-1:0] cnt_p0 [4];
    logic [3:0]       deb_p0;
    logic [3:0]       deb_prev_p1;
    logic [1:0]       pend_p2;
    logic             req_vld_p2;
    logic [1:0]       req_p2;
    logic [1:0]       heading_p2;

    assign raw = {key_left, key_down, key_right, key_up};

    // Lowest set bit wins, giving up > right > down > left.
    function automatic logic [1:0] pick_req(input logic [3:0] pulses);
        logic [1:0] r;
        r = 2'b11;
        if (pulses[2]) r = 2'b10;
        if (pulses[1]) r = 2'b01;
        if (pulses[0]) r = 2'b00;
        return r;
    endfunction

    function automatic logic is_reversal(input logic [1:0] r, input logic [1:0] heading);
        return r == (heading ^ 2'b10);
    endfunction

    // Stage p0: per-key debounce counters and debounced levels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_p0[i] <= '0;
            end
            deb_p0 <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (raw[i] == deb_p0[i]) begin
                    cnt_p0[i] <= '0;
                end else if (cnt_p0[i] == CNT_LAST) begin
                    deb_p0[i] <= raw[i];
                    cnt_p0[i] <= '0;
                end else begin
                    cnt_p0[i] <= cnt_p0[i] + CNT_ONE;
                end
            end
        end
    end

    // Stage p1: rising-edge detect on the debounced levels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_prev_p1 <= '0;
            key_pulse   <= '0;
        end else begin
            deb_prev_p1 <= deb_p0;
            key_pulse   <= deb_p0 & ~deb_prev_p1;
        end
    end

    // Stage p2: request filtering against the heading in force this cycle
    always_comb begin
        req_vld_p2 = |key_pulse;
        req_p2     = pick_req(key_pulse);
        heading_p2 = tick ? pend_p2 : dir;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_p2 <= 2'b01;
            dir     <= 2'b01;
            turn    <= 1'b0;
        end else begin
            if (tick) begin
                dir  <= pend_p2;
                turn <= (pend_p2 != dir);
            end else begin
                turn <= 1'b0;
            end
            if (req_vld_p2 && !is_reversal(req_p2, heading_p2)) begin
                pend_p2 <= req_p2;
            end
        end
    end

endmodule

// File: tb/tb_direction_ctrl.sv
// Randomized scoreboard bench for direction_ctrl against a window-based behavioural model.
module tb_direction_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_up = 1'b0;
    logic       key_right = 1'b0;
    logic       key_down = 1'b0;
    logic       key_left = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] key_pulse;
    logic [1:0] dir;
    logic       turn;

    direction_ctrl #(.DEBOUNCE_CYCLES(N), .CNT_W(20)) dut (
        .clk(clk), .reset(reset),
        .key_up(key_up), .key_right(key_right), .key_down(key_down), .key_left(key_left),
        .tick(tick), .key_pulse(key_pulse), .dir(dir), .turn(turn)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] pulse;
        logic [1:0] dir;
        logic       turn;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Model: a key's debounced level becomes v once the last N raw samples are all v.
    logic [N-1:0] m_hist [4];
    int           m_seen [4];
    logic [3:0]   m_deb, m_rise, m_pulse;
    logic [1:0]   m_pend, m_dir;
    logic         m_turn;

    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_hist[k] = '0;
            m_seen[k] = 0;
        end
        m_deb = '0; m_rise = '0; m_pulse = '0;
        m_pend = 2'd1; m_dir = 2'd1; m_turn = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic t);
        logic [1:0] old_pend, old_dir, heading;
        int r, opposite;
        old_pend = m_pend;
        old_dir  = m_dir;
        heading  = t ? old_pend : old_dir;
        if (t) begin
            m_dir  = old_pend;
            m_turn = (old_pend != old_dir);
        end else begin
            m_turn = 1'b0;
        end
        if (m_pulse != 4'd0) begin
            r = 3;
            for (int i = 3; i >= 0; i--) if (m_pulse[i]) r = i;
            opposite = (int'(heading) + 2) % 4;
            if (r != opposite) m_pend = 2'(r);
        end
        m_pulse = m_rise;
        for (int k = 0; k < 4; k++) begin
            m_hist[k] = {m_hist[k][N-2:0], raw[k]};
            if (m_seen[k] < N) m_seen[k]++;
            m_rise[k] = 1'b0;
            if (m_seen[k] >= N && (&m_hist[k] || ~|m_hist[k]) && m_hist[k][0] != m_deb[k]) begin
                m_deb[k]  = m_hist[k][0];
                m_rise[k] = m_hist[k][0];
            end
        end
    endtask

    // One clock cycle of stimulus; the expected outputs after the coming edge are queued.
    task automatic step(input logic [3:0] k, input logic t, input logic rst_n = 1'b1);
        exp_t e;
        @(negedge clk);
        {key_left, key_down, key_right, key_up} = k;
        tick  = t;
        reset = rst_n;
        if (!rst_n) model_reset();
        else model_edge(k, t);
        e.pulse = m_pulse;
        e.dir   = m_dir;
        e.turn  = m_turn;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [3:0] k, input int n, input int tick_at = -1);
        for (int i = 0; i < n; i++) step(k, (i == tick_at));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("key_pulse", int'(key_pulse), int'(e.pulse));
                check("dir", int'(dir), int'(e.dir));
                check("turn", int'(turn), int'(e.turn));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        logic [3:0] k;
        int len;
        model_reset();
        step(4'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        hold(4'd0, 3);
        // Up held 10 cycles, then a tick commits it.
        hold(4'b0001, 10);
        hold(4'd0, 6);
        hold(4'd0, 3, 0);
        // Short glitch on up: no pulse.
        hold(4'b0001, 3);
        hold(4'd0, 8);
        hold(4'd0, 2, 0);
        // Back to right, then reversal (left) rejected, then down accepted.
        hold(4'b0010, 8);
        hold(4'd0, 4, 1);
        hold(4'b1000, 8);
        hold(4'd0, 4, 1);
        hold(4'b0100, 8);
        hold(4'd0, 4, 1);
        // dir is down here: reset mid-cycle must act before the next edge.
        step(4'b0100, 1'b1, 1'b0);
        #1;
        check("rst_dir", int'(dir), 1);
        check("rst_turn", int'(turn), 0);
        check("rst_key_pulse", int'(key_pulse), 0);
        step(4'd0, 1'b0, 1'b0);
        hold(4'd0, 4);
        // Up and down together with dir right: up wins.
        hold(4'b0101, 8);
        hold(4'd0, 4, 1);
        // Back to right, then down followed by up between ticks: last accepted wins.
        hold(4'b0010, 8);
        hold(4'd0, 4, 1);
        hold(4'b0100, 8);
        hold(4'b0001, 8);
        hold(4'd0, 4, 1);
        // Back to right, queue down, then up pulse coincides with the tick.
        hold(4'b0010, 8);
        hold(4'd0, 4, 1);
        hold(4'b0100, 8);
        hold(4'd0, 2);
        hold(4'b0001, 8, 5);
        hold(4'd0, 4, 1);
        // Randomized segments.
        repeat (400) begin
            k = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) k = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) k = 4'd0;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) step(k, ($urandom_range(0, 5) == 0));
        end
        step(4'd0, 1'b1, 1'b0);
        hold(4'd0, 6);
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/direction_ctrl.md
Name: direction_ctrl

Overview:
- Sits directly downstream of the per-key synchronizers in the Snake-and-Apples design.
- Consumes four synchronized direction-key levels, debounces each one, and turns presses into single-cycle pulses.
- Holds the snake's heading: pending and committed direction registers, with a no-180°-reversal rule.
- The movement logic samples the committed heading once per game tick.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a raw key level must differ from its debounced level before the debounced level flips (use ~500000 on hardware).
CNT_W, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock; all state on posedge.
reset  input  1  asynchronous, active-low reset (low = reset asserted).
key_up  input  1  synchronized key level, active-high.
key_right  input  1  synchronized key level, active-high.
key_down  input  1  synchronized key level, active-high.
key_left  input  1  synchronized key level, active-high.
tick  input  1  one-cycle game-step strobe from the game timer.
key_pulse  output  4  one-cycle press pulses, bit order {left,down,right,up}.
dir  output  2  committed heading: 00 up, 01 right, 10 down, 11 left.
turn  output  1  one-cycle pulse when dir changes.

Behaviour:
- Reset (reset low, asynchronous; takes effect immediately, mid-operation included):
  - all debounce counters = 0; all debounced levels = 0; key_pulse = 0.
  - pending = 01 (right); dir = 01; turn = 0.
- Reset release is synchronous to clk. The first active edge after reset goes high behaves as a normal cycle.
- Debounce, per key, independent:
  - raw == debounced: counter <= 0.
  - raw != debounced: counter increments.
  - When counter reaches DEBOUNCE_CYCLES-1 while raw still differs: debounced <= raw and counter <= 0.
  - Net effect: debounced follows raw DEBOUNCE_CYCLES cycles after raw last changed.
  - A glitch shorter than DEBOUNCE_CYCLES cycles resets the count and produces no change.
- Press pulse:
  - key_pulse[i] is registered and high for exactly one cycle, the cycle after debounced[i] rises 0->1.
  - Releases produce no pulse.
  - A held key produces exactly one pulse.
- Request selection:
  - If several key_pulse bits are high in one cycle, priority is up > right > down > left. Only the winner is considered.
- Pending update (cycle with a winning request r; ref = committed heading used for checks):
  - Without tick: ref = dir.
  - With tick: ref = pending (the value being committed this cycle).
  - r == ref XOR 2'b10 (reversal): ignored; pending is unchanged unless tick rewrites nothing.
  - Otherwise: pending <= r.
  - Several accepted requests between ticks: the last accepted one wins. Each is checked against ref, not against pending.
- Commit on tick:
  - dir <= pending.
  - turn <= 1 for one cycle iff pending != dir before the commit; otherwise turn <= 0.
  - dir and turn update in the cycle after the tick edge.
- Consecutive ticks: each commits independently. A tick with no pending change gives turn = 0.
- A request equal to dir is accepted (pending <= dir), which cancels an earlier pending turn.
- Latency: raw key edge -> key_pulse = DEBOUNCE_CYCLES+1 cycles. key_pulse -> pending = 1 cycle. tick -> dir/turn = 1 cycle.

Test Plan:
1. Reset low mid-run with dir=10 -> dir=01, turn=0, key_pulse=0 immediately, before the next clk edge. Release -> values hold until stimulus.
2. key_up raw high held 10 cycles (DEBOUNCE_CYCLES=4) -> key_pulse=0001 exactly once, 5 cycles after the rise. Next tick -> dir=00 and turn pulses 1 cycle.
3. key_up raw high for 3 cycles then low -> no key_pulse; pending and dir stay 01.
4. dir=01, press key_left (reversal) then tick -> dir stays 01, turn=0. Then press key_down then tick -> dir=10, turn=1.
5. key_up and key_down debounced together with dir=01 -> only up accepted. Tick -> dir=00. Also: press down then up between ticks with dir=01 -> dir=00 after tick (last accepted wins).
6. key_pulse for up arrives in the same cycle as tick with pending=10, dir=01 -> dir=10 committed, turn=1, up rejected (reversal of 10), pending stays 10.
